// File: rtl/sram_scan_display.sv
// Post-sort SRAM reader: fetches N_WORDS bytes one by one and holds each on the 7-segment displays for DWELL cycles.
// Define SCAN_SORT_CHECK_EN to add a sticky sort_err flag for out-of-order neighbours within a pass.
module sram_scan_display #(
   parameter int N_WORDS   = 4,
   parameter int AW        = 2,
   parameter int DW        = 8,
   parameter int READ_WAIT = 2,
   parameter int DWELL     = 50_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          loop,
   output logic [AW-1:0] sram_addr,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n,
   input  logic [DW-1:0] sram_dq,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] cur_data,
   output logic [6:0]    hex0,
   output logic [6:0]    hex1,
   output logic [6:0]    hex2
`ifdef SCAN_SORT_CHECK_EN
   ,
   output logic          sort_err
`endif
);

   localparam int MAXC = (READ_WAIT > DWELL) ? READ_WAIT : DWELL;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] READ_LAST = CW'(READ_WAIT - 1);
   localparam logic [CW-1:0] SHOW_LAST = CW'(DWELL - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(N_WORDS - 1);

   typedef enum logic [2:0] {IDLE, READ, SAMPLE, SHOW, FIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_d;
   logic [AW-1:0] disp_addr;
   logic [3:0]    addr_digit;
   logic          valid;
   logic          sample;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h27;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = sram_addr;
      sample  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         READ: begin
            if (cnt_q == READ_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SAMPLE: begin
            sample  = 1'b1;
            state_d = SHOW;
            cnt_d   = '0;
         end
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               // Address only advances below the last word, so it never wraps by overflow.
               if (sram_addr != ADDR_LAST) begin
                  addr_d  = sram_addr + AW'(1);
                  state_d = READ;
               end else if (loop) begin
                  addr_d  = '0;
                  state_d = READ;
               end else begin
                  state_d = FIN;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort overrides everything, including a pending sample or start.
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         addr_d  = sram_addr;
         sample  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sram_addr <= '0;
         cur_data  <= '0;
         disp_addr <= '0;
         valid     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sram_addr <= addr_d;
         if (sample) begin
            cur_data  <= sram_dq;
            disp_addr <= sram_addr;
            valid     <= 1'b1;
         end
      end
   end

   assign sram_ce_n  = !((state_q == READ) || (state_q == SAMPLE));
   assign sram_oe_n  = sram_ce_n;
   assign sram_we_n  = 1'b1;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);
   assign addr_digit = 4'(disp_addr);
   assign hex0       = valid ? seg7(cur_data[3:0]) : 7'h7F;
   assign hex1       = valid ? seg7(cur_data[7:4]) : 7'h7F;

`ifdef SCAN_SORT_CHECK_EN
   logic first;
   logic accept;
   logic new_pass;

   // A pass begins at an accepted start or at a loop wrap; its first sample has no predecessor.
   assign accept   = (state_q == IDLE) && start && !abort;
   assign new_pass = accept || ((state_q == SHOW) && (cnt_q == SHOW_LAST) &&
                                (sram_addr == ADDR_LAST) && loop && !abort);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first    <= 1'b0;
         sort_err <= 1'b0;
      end else begin
         if (new_pass) begin
            first <= 1'b1;
         end else if (sample) begin
            first <= 1'b0;
         end
         if (accept) begin
            sort_err <= 1'b0;
         end else if (sample && !first && (sram_dq < cur_data)) begin
            sort_err <= 1'b1;
         end
      end
   end

   assign hex2 = !valid ? 7'h7F : (sort_err ? 7'h06 : seg7(addr_digit));
`else
   assign hex2 = valid ? seg7(addr_digit) : 7'h7F;
`endif

endmodule

// File: tb/tb_sram_scan_display.sv
// Bench for sram_scan_display: directed scenarios with literal expectations, then random
// start/abort/loop traffic; a timing-arithmetic model is compared against every output each cycle.
`timescale 1ns/1ps
module tb_sram_scan_display;
   localparam int N   = 4;
   localparam int AW  = 2;
   localparam int DW  = 8;
   localparam int RW  = 2;
   localparam int DWL = 4;
   localparam int P   = RW + 1 + DWL;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic loop = 1'b0;
   logic [AW-1:0] sram_addr;
   logic sram_ce_n, sram_oe_n, sram_we_n;
   logic [DW-1:0] sram_dq;
   logic busy, done;
   logic [DW-1:0] cur_data;
   logic [6:0] hex0, hex1, hex2;
`ifdef SCAN_SORT_CHECK_EN
   logic sort_err;
`endif

   logic [7:0] mem [N];
   logic [6:0] seg [16];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic prev_ce = 1'b1;
   logic [AW-1:0] rd_addr[$];
   int rd_cyc[$];

   // model state
   bit m_busy, m_fin, m_valid, m_err, m_first;
   int m_j, m_daddr;
   logic [7:0] m_data;

   always #5 clk = ~clk;

   assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;

   sram_scan_display #(
      .N_WORDS(N), .AW(AW), .DW(DW), .READ_WAIT(RW), .DWELL(DWL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_dq(sram_dq), .busy(busy), .done(done),
      .cur_data(cur_data), .hex0(hex0), .hex1(hex1), .hex2(hex2)
`ifdef SCAN_SORT_CHECK_EN
      , .sort_err(sort_err)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: position within a scan is m_j cycles after the start edge; word = m_j / P, phase = m_j % P.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 0; m_fin = 0; m_valid = 0; m_err = 0; m_first = 0;
         m_j = 0; m_daddr = 0; m_data = 8'h00;
      end else if (abort) begin
         m_busy = 0; m_fin = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_j = 0; m_first = 1; m_err = 0;
         end
      end else if (m_fin) begin
         m_busy = 0; m_fin = 0;
      end else begin
         int o, w;
         o = m_j % P;
         w = (m_j / P) % N;
         if (o == RW) begin
            if (!m_first && mem[w] < m_data) m_err = 1;
            m_data = mem[w]; m_daddr = w; m_valid = 1; m_first = 0;
         end
         if (o == P - 1 && w == N - 1) begin
            if (loop) begin
               m_j++; m_first = 1;
            end else begin
               m_fin = 1;
            end
         end else begin
            m_j++;
         end
      end
   end

   initial forever begin
      logic e_ce;
      logic [6:0] e_hex2;
      @(negedge clk);
      e_ce = 1'b1;
      if (m_busy && !m_fin) begin
         e_ce = ((m_j % P) <= RW) ? 1'b0 : 1'b1;
         chk("addr", sram_addr, (m_j / P) % N);
      end
      e_hex2 = m_valid ? seg[m_daddr] : 7'h7F;
`ifdef SCAN_SORT_CHECK_EN
      if (m_valid && m_err) e_hex2 = 7'h06;
      chk("sort_err", sort_err, m_err);
`endif
      chk("busy", busy, m_busy);
      chk("done", done, m_fin);
      chk("ce_n", sram_ce_n, e_ce);
      chk("oe_n", sram_oe_n, e_ce);
      chk("we_n", sram_we_n, 1);
      chk("cur_data", cur_data, m_data);
      chk("hex0", hex0, m_valid ? seg[m_data[3:0]] : 7'h7F);
      chk("hex1", hex1, m_valid ? seg[m_data[7:4]] : 7'h7F);
      chk("hex2", hex2, e_hex2);
   end

   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && !sram_ce_n && prev_ce) begin
         rd_addr.push_back(sram_addr);
         rd_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      prev_ce = sram_ce_n;
   end

   task automatic clear_log();
      rd_addr.delete();
      rd_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_reads(input int n, input string tag);
      for (int i = 0; i < 200 && rd_addr.size() < n; i++) @(negedge clk);
      chk(tag, rd_addr.size() >= n, 1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      chk(tag, busy, 0);
   endtask

   initial begin
      seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
      mem = '{8'h03, 8'h07, 8'h0A, 8'hF1};
      repeat (2) @(negedge clk);

      // reset state
      chk("t1_ce_n", sram_ce_n, 1);
      chk("t1_oe_n", sram_oe_n, 1);
      chk("t1_we_n", sram_we_n, 1);
      chk("t1_busy", busy, 0);
      chk("t1_hex0", hex0, 7'h7F);
      chk("t1_hex1", hex1, 7'h7F);
      chk("t1_hex2", hex2, 7'h7F);
      rst_n = 1'b1;
      @(negedge clk);

      // first sample 3 cycles after start, then the full non-loop scan
      clear_log();
      pulse_start();
      repeat (3) @(negedge clk);
      chk("t1_cur_data", cur_data, 8'h03);
      chk("t1_hex0_3", hex0, 7'h30);
      chk("t1_hex1_0", hex1, 7'h40);
      chk("t1_hex2_0", hex2, 7'h40);
      wait_idle("t2_idle");
      chk("t2_nreads", rd_addr.size(), 4);
      for (int i = 0; i < 4 && i < rd_addr.size(); i++)
         chk($sformatf("t2_addr%0d", i), rd_addr[i], i);
      for (int i = 1; i < 4 && i < rd_cyc.size(); i++)
         chk($sformatf("t2_gap%0d", i), rd_cyc[i] - rd_cyc[i-1], 7);
      chk("t2_done_cycles", done_cnt, 1);
      chk("t2_cur_data", cur_data, 8'hF1);
      chk("t2_hex1_F", hex1, 7'h0E);

      // loop mode wraps to address 0; a second start mid-scan is ignored
      loop = 1'b1;
      clear_log();
      pulse_start();
      repeat (10) @(negedge clk);
      pulse_start();
      wait_reads(5, "t3_wrap_seen");
      if (rd_addr.size() >= 5) chk("t3_wrap_addr", rd_addr[4], 0);
      if (rd_addr.size() >= 2) chk("t3_second_addr", rd_addr[1], 1);
      repeat (3) @(negedge clk);
      chk("t3_cur_data", cur_data, 8'h03);
      chk("t3_no_done", done_cnt, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      loop = 1'b0;
      chk("t3_abort_idle", busy, 0);

      // abort during READ of address 2
      clear_log();
      pulse_start();
      wait_reads(3, "t4_read2_seen");
      if (rd_addr.size() >= 3) chk("t4_read_addr", rd_addr[2], 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_ce_n", sram_ce_n, 1);
      chk("t4_cur_data", cur_data, 8'h07);
      chk("t4_hex0", hex0, 7'h78);
      repeat (3) @(negedge clk);
      chk("t4_no_done", done_cnt, 0);

      // asynchronous reset during SHOW
      clear_log();
      pulse_start();
      wait_reads(1, "t5_read0_seen");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_ce_n", sram_ce_n, 1);
      chk("t5_addr", sram_addr, 0);
      chk("t5_cur_data", cur_data, 0);
      chk("t5_hex0", hex0, 7'h7F);
      chk("t5_hex2", hex2, 7'h7F);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
      pulse_start();
      wait_reads(1, "t5_restart_seen");
      if (rd_addr.size() >= 1) chk("t5_restart_addr", rd_addr[0], 0);
      wait_idle("t5_idle");

`ifdef SCAN_SORT_CHECK_EN
      mem = '{8'h03, 8'h0A, 8'h07, 8'hF1};
      clear_log();
      pulse_start();
      wait_reads(3, "t6_read2_seen");
      repeat (3) @(negedge clk);
      chk("t6_sort_err", sort_err, 1);
      chk("t6_hex2_E", hex2, 7'h06);
      wait_idle("t6_idle");
      pulse_start();
      chk("t6_cleared", sort_err, 0);
      wait_idle("t6_idle2");
`endif

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 15) == 0);
         abort = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 29) == 0) loop = ~loop;
         if (!busy && $urandom_range(0, 3) == 0)
            for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      loop = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
